// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU-level constants and the boot loader state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int INSTR_W     = 18;  // instruction word width, opcode in [17:14]
  localparam int OPCODE_W    = 4;
  localparam int IMEM_ADDR_W = 10;  // instruction memory depth = 2**IMEM_ADDR_W

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_B0     = 3'd3,
    ST_B1     = 3'd4,
    ST_B2     = 3'd5,
    ST_WRITE  = 3'd6,
    ST_DONE   = 3'd7
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : program_loader_if
// Purpose  : Byte-stream input, instruction-memory write port and CPU control
//            signals of the boot loader, bundled as one interface.
// Ports    : start, in_valid, in_data        (master -> loader)
//            in_ready, imem_we, imem_addr,
//            imem_wdata, cpu_reset, done, err (loader -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface program_loader_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = cpu_pkg::INSTR_W
);

  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              err;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, err
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, err
  );

endinterface
`default_nettype wire

// File: rtl/loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : loader_word_packer
// Purpose  : Packs three stream bytes (big-endian) into one instruction word.
// Ports    : clk, reset        clock / async active-high reset
//            load_i            first byte of a word (clears older contents)
//            shift_i           following bytes, shifted in from the right
//            byte_i[7:0]       stream byte
//            word_o[INSTR_W-1:0] packed instruction word
// Revision : 1.0 - initial release
// ============================================================================
module loader_word_packer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o
);

  // Only 18 bits are kept: after two further shifts the upper six bits of
  // the first byte fall off the top, leaving byte0[1:0] in word[17:16].
  logic [INSTR_W-1:0] sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= {{(INSTR_W-8){1'b0}}, byte_i};
    end else if (shift_i) begin
      sr_q <= {sr_q[INSTR_W-9:0], byte_i};
    end
  end

  assign word_o = sr_q;

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Boot loader. Receives a byte stream (16-bit big-endian word
//            count, then 3 bytes per word), writes the words sequentially
//            into instruction memory and holds the CPU in reset until the
//            whole image is written.
// Ports    : clk        system clock, rising edge
//            reset      asynchronous active-high reset
//            bus.slave  start/in_valid/in_data in; in_ready, imem_we,
//                       imem_addr, imem_wdata, cpu_reset, done, err out
// Revision : 1.0 - initial release
// ============================================================================
module program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
)(
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_HDR_HI = ST_HDR_HI;
  localparam logic [2:0] S_HDR_LO = ST_HDR_LO;
  localparam logic [2:0] S_B0     = ST_B0;
  localparam logic [2:0] S_B1     = ST_B1;
  localparam logic [2:0] S_B2     = ST_B2;
  localparam logic [2:0] S_WRITE  = ST_WRITE;
  localparam logic [2:0] S_DONE   = ST_DONE;

  localparam logic [16:0] C_DEPTH = 17'(1) << ADDR_W;

  logic [2:0]         state_q, state_d;
  logic [15:0]        n_q, n_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;      // one extra bit: N = depth never wraps
  logic               err_q, err_d;
  logic               in_ready_q, imem_we_q, done_q, cpu_reset_q;
  logic               w_hs, w_pk_load, w_pk_shift;
  logic [15:0]        w_n_full;
  logic [INSTR_W-1:0] w_word;

  assign w_hs     = bus.in_valid & in_ready_q;
  assign w_n_full = {n_q[15:8], bus.in_data};

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    w_pk_load  = 1'b0;
    w_pk_shift = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_HDR_HI;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_HDR_HI: begin
        if (w_hs) begin
          n_d[15:8] = bus.in_data;
          state_d   = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (w_hs) begin
          n_d[7:0] = bus.in_data;
          if (w_n_full == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, w_n_full} > C_DEPTH) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_B0;
          end
        end
      end
      S_B0: begin
        if (w_hs) begin
          w_pk_load = 1'b1;
          state_d   = S_B1;
        end
      end
      S_B1: begin
        if (w_hs) begin
          w_pk_shift = 1'b1;
          state_d    = S_B2;
        end
      end
      S_B2: begin
        if (w_hs) begin
          w_pk_shift = 1'b1;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        // Counter still holds this word's index: the last word is index N-1.
        if (16'(cnt_q) == n_q - 16'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_B0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      done_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
                     (state_d == S_B0) || (state_d == S_B1) || (state_d == S_B2);
      imem_we_q   <= (state_d == S_WRITE);
      done_q      <= (state_d == S_DONE);
      cpu_reset_q <= (state_d != S_DONE);
    end
  end

  loader_word_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (w_pk_load),
    .shift_i (w_pk_shift),
    .byte_i  (bus.in_data),
    .word_o  (w_word)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = cnt_q[ADDR_W-1:0];
  assign bus.imem_wdata = w_word;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Directed self-checking bench for program_loader. Expected memory
//            writes are queued when a word is streamed in and compared when
//            the loader raises imem_we.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;
  import cpu_pkg::*;

  localparam int AW = IMEM_ADDR_W;
  localparam int IW = cpu_pkg::INSTR_W;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_writes = 0;
  wr_t  exp_q[$];

  program_loader_if #(.ADDR_W(AW), .DATA_W(IW)) bus ();

  program_loader #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.imem_we === 1'b1) begin
      wr_t e;
      n_writes++;
      check("in_ready_in_write", 32'(bus.in_ready), 32'd0);
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("imem_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("imem_wdata", 32'(bus.imem_wdata), 32'(e.data));
      end
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    int k;
    gap = (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("handshake_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] addr, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2, input int gap_max);
    exp_q.push_back({addr, b0[1:0], b1, b2});
    send_byte(b0, gap_max);
    send_byte(b1, gap_max);
    send_byte(b2, gap_max);
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1 reset = 1'b1;
    #1;
    check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_imem_we", 32'(bus.imem_we), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_imem_wdata", 32'(bus.imem_wdata), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Three-word image; start pulses during the load must be ignored.
    start_pulse();
    check("t1_ready_after_start", 32'(bus.in_ready), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_word(10'd0, 8'h02, 8'h00, 8'h04, 0);
    start_pulse();
    start_pulse();
    check("t1_ready_after_ignored_start", 32'(bus.in_ready), 32'd1);
    check("t1_cpu_reset_loading", 32'(bus.cpu_reset), 32'd1);
    send_word(10'd1, 8'h00, 8'h90, 8'h00, 0);
    send_word(10'd2, 8'h02, 8'h04, 8'h00, 0);
    check("t1_we_last", 32'(bus.imem_we), 32'd1);
    check("t1_cpu_reset_in_last_write", 32'(bus.cpu_reset), 32'd1);
    @(negedge clk);
    check("t1_cpu_reset_released", 32'(bus.cpu_reset), 32'd0);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_in_ready_done", 32'(bus.in_ready), 32'd0);
    check("t1_writes", 32'(n_writes), 32'd3);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reload from DONE with an empty image.
    start_pulse();
    check("t2_cpu_reset_reasserted", 32'(bus.cpu_reset), 32'd1);
    check("t2_done_cleared", 32'(bus.done), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("t2_writes", 32'(n_writes), 32'd3);

    // Oversized header: 1025 words.
    start_pulse();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check("t3_err", 32'(bus.err), 32'd1);
    check("t3_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("t3_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("t3_idle_not_ready", 32'(bus.in_ready), 32'd0);
    check("t3_writes", 32'(n_writes), 32'd3);

    // Four words with random in_valid gaps; one word has byte0 = 0xFD.
    start_pulse();
    check("t4_err_cleared", 32'(bus.err), 32'd0);
    send_byte(8'h00, 3);
    send_byte(8'h04, 3);
    send_word(10'd0, 8'hFD, 8'h12, 8'h34, 3);
    send_word(10'd1, 8'h03, 8'hFF, 8'hFF, 3);
    send_word(10'd2, 8'h01, 8'hA5, 8'h5A, 3);
    send_word(10'd3, 8'h00, 8'h00, 8'h01, 3);
    @(negedge clk);
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("t4_writes", 32'(n_writes), 32'd7);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while in B1 of the second word, then a clean reload.
    start_pulse();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_word(10'd0, 8'h01, 8'h23, 8'h45, 0);
    send_byte(8'h02, 0);
    check("t5_in_b1_ready", 32'(bus.in_ready), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("t5_async_in_ready", 32'(bus.in_ready), 32'd0);
    check("t5_async_imem_we", 32'(bus.imem_we), 32'd0);
    check("t5_async_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("t5_async_imem_wdata", 32'(bus.imem_wdata), 32'd0);
    check("t5_async_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.start = 1'b1;          // coincident with reset: must be ignored
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("t5_start_under_reset", 32'(bus.in_ready), 32'd0);
    check("t5_cpu_reset_held", 32'(bus.cpu_reset), 32'd1);
    start_pulse();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(10'd0, 8'h02, 8'hC0, 8'hDE, 0);
    send_word(10'd1, 8'h01, 8'h0B, 8'hAD, 0);
    @(negedge clk);
    check("t5_done", 32'(bus.done), 32'd1);
    check("t5_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("t5_writes", 32'(n_writes), 32'd10);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
